// File: rtl/command_parser_regfile_if.sv
// Command/configuration bundle between the UART nibble framer and the command parser register file.
// The parser takes the slave side and the framer or bench takes the master side.
interface command_parser_regfile_if #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned VAL_W  = 4,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned STEP_W = 12
);
  logic              I_command_flag;
  logic [CTRL_W-1:0] I_ctrl_command;
  logic [VAL_W-1:0]  I_value_command;
  logic              O_video_move_en;
  logic              O_move_home;
  logic [NUM_CH-1:0] O_ch_en;
  logic [1:0]        O_splice_mode;
  logic [STEP_W-1:0] O_move_step;
  logic              O_cfg_update;
  logic              O_cmd_err;

  modport master (
    output I_command_flag, I_ctrl_command, I_value_command,
    input  O_video_move_en, O_move_home, O_ch_en, O_splice_mode,
           O_move_step, O_cfg_update, O_cmd_err
  );

  modport slave (
    input  I_command_flag, I_ctrl_command, I_value_command,
    output O_video_move_en, O_move_home, O_ch_en, O_splice_mode,
           O_move_step, O_cfg_update, O_cmd_err
  );
endinterface

// File: rtl/command_parser_regfile.sv
// UART command decoder and register file for the quad-splicer controls, with multi-beat move-step assembly.
// Optional macro CMD_TIMEOUT_EN adds an inter-beat idle timeout of TIMEOUT_CYC cycles while in COLLECT.
//
// state     | meaning
// S_IDLE    | no frame open; every flagged command is decoded directly
// S_COLLECT | move-step frame open; ctrl=F beats are shifted in, anything else aborts the frame
module command_parser_regfile #(
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned VAL_W       = 4,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned STEP_BEATS  = 3,
  parameter logic [VAL_W*STEP_BEATS-1:0] STEP_INIT = 'd4,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input logic clk,
  input logic rst_n,
  command_parser_regfile_if.slave bus
);
  localparam int unsigned STEP_W = VAL_W * STEP_BEATS;
  localparam int unsigned BC_W   = $clog2(STEP_BEATS + 1);
  localparam logic [CTRL_W-1:0] OP_MOVE = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_CHEN = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_MODE = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_STEP = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_CONT = '1;

  if (VAL_W < NUM_CH || VAL_W < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("command_parser_regfile: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [STEP_W-1:0] shift_q, shift_d;
  logic              move_en_q, move_en_d;
  logic              home_q, home_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [1:0]        mode_q, mode_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              cfg_q, cfg_d;
  logic              err_q, err_d;
  logic              idle_dec;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      shift_q    <= '0;
      move_en_q  <= 1'b0;
      home_q     <= 1'b0;
      ch_en_q    <= '1;
      mode_q     <= 2'd0;
      step_q     <= STEP_INIT;
      cfg_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      move_en_q  <= move_en_d;
      home_q     <= home_d;
      ch_en_q    <= ch_en_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      cfg_q      <= cfg_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shift_d    = shift_q;
    move_en_d  = move_en_q;
    home_d     = 1'b0;
    ch_en_d    = ch_en_q;
    mode_d     = mode_q;
    step_d     = step_q;
    cfg_d      = 1'b0;
    err_d      = 1'b0;
    idle_dec   = 1'b0;
`ifdef CMD_TIMEOUT_EN
    tmo_d      = '0;
`endif
    if (bus.I_command_flag) begin
      if (state_q == S_COLLECT) begin
        if (bus.I_ctrl_command == OP_CONT) begin
          shift_d    = (shift_q << VAL_W) | STEP_W'(bus.I_value_command);
          beat_cnt_d = beat_cnt_q + BC_W'(1);
          if (beat_cnt_d == BC_W'(STEP_BEATS)) begin
            step_d  = shift_d;
            cfg_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          // Abort: drop the partial frame, then the same command is decoded as if idle.
          err_d      = 1'b1;
          state_d    = S_IDLE;
          shift_d    = '0;
          beat_cnt_d = '0;
          idle_dec   = 1'b1;
        end
      end else begin
        idle_dec = 1'b1;
      end

      if (idle_dec) begin
        if (bus.I_ctrl_command == OP_MOVE) begin
          move_en_d = bus.I_value_command[0];
          home_d    = bus.I_value_command[1];
          cfg_d     = 1'b1;
        end else if (bus.I_ctrl_command == OP_CHEN) begin
          ch_en_d = bus.I_value_command[NUM_CH-1:0];
          cfg_d   = 1'b1;
        end else if (bus.I_ctrl_command == OP_MODE) begin
          if (bus.I_value_command[1:0] != 2'd3) begin
            mode_d = bus.I_value_command[1:0];
            cfg_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.I_ctrl_command == OP_STEP) begin
          shift_d    = STEP_W'(bus.I_value_command);
          beat_cnt_d = BC_W'(1);
          if (STEP_BEATS == 1) begin
            step_d  = STEP_W'(bus.I_value_command);
            cfg_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
`ifdef CMD_TIMEOUT_EN
    else if (state_q == S_COLLECT) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d    = S_IDLE;
        shift_d    = '0;
        beat_cnt_d = '0;
        err_d      = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif
  end

  always_comb begin
    bus.O_video_move_en = move_en_q;
    bus.O_move_home     = home_q;
    bus.O_ch_en         = ch_en_q;
    bus.O_splice_mode   = mode_q;
    bus.O_move_step     = step_q;
    bus.O_cfg_update    = cfg_q;
    bus.O_cmd_err       = err_q;
  end
endmodule
